// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   fetch_state_t    - sequencer state encoding
//   RESET_PC_DEFAULT - boot address loaded while rst_n is low
//   INSTR_BYTES      - byte stride between sequential instructions
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0020;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// fetch_pc_reg
// Architectural fetch PC register. The sequencer computes the next PC and
// raises load for every cycle in which the PC should change.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset, loads RESET_PC
//   load     in   capture next_pc on the coming clock edge
//   next_pc  in   [31:0] value to capture
//   pc       out  [31:0] current fetch PC
module fetch_pc_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] next_pc,
  output logic [31:0] pc
);

  // PC holds its value unless the sequencer explicitly loads a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller. Owns the fetch PC, issues one imem request
// at a time, captures the returned word and presents {pc, instr} to decode.
// Redirects from later stages steer the PC and squash wrong-path fetches.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/ready/addr          fetch request channel (addr = pc)
//   imem_rsp_valid/data                response, one per accepted request
//   redirect_valid/pc                  single-cycle redirect pulse + target
//   if_valid/ready, if_pc, if_instr,   registered instruction handed to
//   if_pc_plus4                        decode
//   misalign_fault                     sticky: last redirect was misaligned
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_fault
);

  fetch_state_t state, state_next;
  logic         squash, squash_next;
  logic         fault, fault_next;
  logic         pc_load;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic         capture;
  logic         req_fire;
  logic         redirect_aligned, redirect_misaligned;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .next_pc (pc_next),
    .pc      (pc)
  );

  // Sequential increment wraps naturally in 32 bits.
  assign pc_plus4            = pc + INSTR_BYTES;
  assign req_fire            = (state == S_FETCH) && imem_req_ready;
  assign redirect_aligned    = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  assign imem_req_valid = (state == S_FETCH);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == S_HOLD);
  assign misalign_fault = fault;

  // State, squash and fault registers; all reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      squash <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_next;
      squash <= squash_next;
      fault  <= fault_next;
    end
  end

  // Next-state logic. Normal sequencing is decided first, then a redirect
  // is layered on top because it overrides whatever sequencing chose.
  // squash marks an outstanding request whose response must be discarded.
  always_comb begin
    state_next  = state;
    squash_next = squash;
    fault_next  = fault;
    pc_load     = 1'b0;
    pc_next     = pc;
    capture     = 1'b0;

    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (req_fire) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          squash_next = 1'b0;
          if (squash || redirect_valid) begin
            state_next = S_FETCH;
          end else begin
            capture    = 1'b1;
            pc_load    = 1'b1;
            pc_next    = pc_plus4;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD:  if (if_ready) state_next = S_FETCH;
      S_HALT:  if (imem_rsp_valid) squash_next = 1'b0;
      default: state_next = S_IDLE;
    endcase

    if (redirect_aligned) begin
      pc_load = 1'b1;
      pc_next = redirect_pc;
      case (state)
        S_IDLE, S_HOLD: state_next = S_FETCH;
        S_FETCH: if (req_fire) squash_next = 1'b1;
        S_WAIT:  if (!imem_rsp_valid) squash_next = 1'b1;
        S_HALT: begin
          fault_next = 1'b0;
          // A stale response still due must be drained before refetching.
          state_next = squash_next ? S_WAIT : S_FETCH;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (redirect_misaligned) begin
      fault_next = 1'b1;
      state_next = S_HALT;
      pc_load    = 1'b0;
      pc_next    = pc;
      capture    = 1'b0;
      if (req_fire || ((state == S_WAIT) && !imem_rsp_valid)) begin
        squash_next = 1'b1;
      end
    end
  end

  // Decode-facing registers load only when a good-path word is captured,
  // so they stay stable throughout HOLD backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc       <= 32'h0;
      if_instr    <= 32'h0;
      if_pc_plus4 <= 32'h0;
    end else if (capture) begin
      if_pc       <= pc;
      if_instr    <= imem_rsp_data;
      if_pc_plus4 <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a small imem responder model
// (configurable response delay) advanced once per cycle on the falling edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        misalign_fault;

  int          tests_run;
  int          tests_failed;
  int          pend_cnt;
  int          rsp_delay;
  logic [31:0] pend_addr;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4),
    .misalign_fault (misalign_fault)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction word stored at an address.
  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                               input logic ir);
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = ir;
  endtask

  // Advance to the next falling edge and run the imem model for the
  // coming rising edge: deliver due responses, then record acceptances.
  task automatic tick();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend_addr);
          checkOutput("rsp_state", {30'h0, imem_req_valid, if_valid}, 32'h0);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checkOutput("one_outstanding",
                    {31'h0, (pend_cnt == 0) && !imem_rsp_valid}, 32'h1);
        pend_cnt  = rsp_delay;
        pend_addr = imem_req_addr;
      end
    end
  endtask

  task automatic expectPresent(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] plus4);
    checkOutput({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    checkOutput({tag, "_pc"}, if_pc, pc);
    checkOutput({tag, "_instr"}, if_instr, instr);
    checkOutput({tag, "_plus4"}, if_pc_plus4, plus4);
  endtask

  task automatic expectResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
    checkOutput({tag, "_req_addr"}, imem_req_addr, 32'h0040_0020);
    checkOutput({tag, "_if_valid"}, {31'h0, if_valid}, 32'h0);
    checkOutput({tag, "_if_pc"}, if_pc, 32'h0);
    checkOutput({tag, "_if_instr"}, if_instr, 32'h0);
    checkOutput({tag, "_if_plus4"}, if_pc_plus4, 32'h0);
    checkOutput({tag, "_fault"}, {31'h0, misalign_fault}, 32'h0);
  endtask

  // Directed sequence covering boot, streaming, backpressure, squash,
  // redirects, misalignment, PC wrap and asynchronous reset.
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    pend_cnt       = 0;
    rsp_delay      = 1;
    pend_addr      = 32'h0;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    #1 rst_n = 1'b0;
    #1 expectResetOutputs("reset");

    tick();
    tick();
    rst_n = 1'b1;

    // Boot and sequential stream at one instruction per three cycles.
    tick();
    checkOutput("boot_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("boot_addr", imem_req_addr, 32'h0040_0020);
    tick();
    tick();
    expectPresent("seq0", 32'h0040_0020, 32'hC0DE_0020, 32'h0040_0024);
    tick();
    tick();
    tick();
    expectPresent("seq1", 32'h0040_0024, 32'hC0DE_0024, 32'h0040_0028);
    tick();
    tick();
    tick();
    expectPresent("seq2", 32'h0040_0028, 32'hC0DE_0028, 32'h0040_002C);

    // Backpressure: decode stalls for five cycles.
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectPresent("stall", 32'h0040_0028, 32'hC0DE_0028, 32'h0040_002C);
      checkOutput("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("release_addr", imem_req_addr, 32'h0040_002C);
    tick();
    tick();
    expectPresent("seq3", 32'h0040_002C, 32'hC0DE_002C, 32'h0040_0030);

    // Squash: redirect while WAIT, response four cycles late.
    rsp_delay = 4;
    tick();
    checkOutput("sq_req_addr", imem_req_addr, 32'h0040_0030);
    tick();
    applyStimulus(1'b1, 32'h0040_0100, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("sq_redirect_addr", imem_req_addr, 32'h0040_0100);
    checkOutput("sq_no_req", {31'h0, imem_req_valid}, 32'h0);
    tick();
    tick();
    rsp_delay = 1;
    checkOutput("sq_late_rsp", {31'h0, imem_rsp_valid}, 32'h1);
    tick();
    checkOutput("sq_not_presented0", {31'h0, if_valid}, 32'h0);
    checkOutput("sq_refetch_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("sq_refetch_addr", imem_req_addr, 32'h0040_0100);
    tick();
    checkOutput("sq_not_presented1", {31'h0, if_valid}, 32'h0);
    tick();
    expectPresent("sq_target", 32'h0040_0100, 32'hC0DE_0100, 32'h0040_0104);

    // Redirect in HOLD while decode is ready: held word is dropped.
    applyStimulus(1'b1, 32'h0040_0300, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("hold_rd_if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("hold_rd_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("hold_rd_addr", imem_req_addr, 32'h0040_0300);
    tick();
    tick();
    expectPresent("hold_rd_target", 32'h0040_0300, 32'hC0DE_0300, 32'h0040_0304);

    // Misaligned redirect halts fetch; an aligned one recovers.
    applyStimulus(1'b1, 32'h0040_0102, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis_fault", {31'h0, misalign_fault}, 32'h1);
    checkOutput("mis_if_valid", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
      tick();
    end
    checkOutput("mis_still_fault", {31'h0, misalign_fault}, 32'h1);
    applyStimulus(1'b1, 32'h0040_0200, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mis_cleared", {31'h0, misalign_fault}, 32'h0);
    checkOutput("mis_req_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("mis_addr", imem_req_addr, 32'h0040_0200);
    tick();
    tick();
    expectPresent("mis_target", 32'h0040_0200, 32'hC0DE_0200, 32'h0040_0204);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    expectPresent("wrap_top", 32'hFFFF_FFFC, 32'hC0DE_FFFC, 32'h0000_0000);
    rsp_delay = 3;
    tick();
    checkOutput("wrap_next_valid", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    tick();

    // Asynchronous reset in the middle of WAIT.
    #2 rst_n = 1'b0;
    pend_cnt = 0;
    #1 expectResetOutputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reboot_addr", imem_req_addr, 32'h0040_0020);
    checkOutput("reboot_valid", {31'h0, imem_req_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the architectural fetch PC and sequences it against the instruction memory. It issues one fetch at a time to imem over a valid/ready request channel. It captures the returned word and presents {pc, instr} to decode over a valid/ready channel. It steers the PC on sequential flow (+4) and on redirects (branch, jump, jr, exception) from later stages, squashing any wrong-path fetch in flight.

## Interface
- RESET_PC, 32'h00400020, boot address loaded at reset

- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request this cycle
- imem_req_addr  out  32  fetch address (= current PC)
- imem_rsp_valid  in  1  response word valid (one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  single-cycle redirect pulse from execute/exception logic
- redirect_pc  in  32  redirect target
- if_valid  out  1  fetched instruction valid to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction word
- if_pc_plus4  out  32  if_pc + 4
- misalign_fault  out  1  sticky: last redirect target had redirect_pc[1:0] != 0

## Operation
- State machine with states IDLE, FETCH, WAIT, HOLD, HALT, plus `pc` (32b) and `squash` (1b).
- Reset (async, rst_n low): state=IDLE, pc=RESET_PC, squash=0, fault=0.
  - Output reset values: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_pc_plus4=0, misalign_fault=0.
- imem_req_valid=1 only in FETCH. imem_req_addr=pc always. if_valid=1 only in HOLD.
- Redirect precedence:
  - Aligned redirect: overrides all same-cycle sequencing. pc<=redirect_pc.
  - Misaligned redirect: fault<=1, state<=HALT. squash<=1 if a request is outstanding after this cycle.
- IDLE: next cycle -> FETCH.
- FETCH:
  - Handshake (valid&&ready) -> WAIT. If an aligned redirect arrives the same cycle, set squash=1 and pc=redirect_pc.
  - Redirect without handshake: pc updated, stay FETCH. imem must tolerate the address changing while a request is unaccepted.
- WAIT:
  - rsp_valid with squash=1 or redirect same cycle: discard the word, squash<=0, -> FETCH.
  - rsp_valid otherwise: if_pc<=pc, if_instr<=data, if_pc_plus4<=pc+4, pc<=pc+4, -> HOLD.
  - Redirect without rsp: squash<=1, pc<=redirect_pc, stay WAIT.
- HOLD:
  - Redirect: drop the held instruction (wrong path, not consumed even if if_ready=1), -> FETCH.
  - if_ready without redirect: -> FETCH.
  - Otherwise hold all if_* stable.
- HALT:
  - No requests issued. rsp_valid clears squash and its word is discarded.
  - Aligned redirect: pc<=redirect_pc, fault<=0. Next state is WAIT if squash is still 1 (stale response pending), else FETCH.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0). No other width extension.
- Invariant: at most one imem request outstanding. imem responses arriving in IDLE/FETCH/HOLD are protocol errors (assert in bench).

## Timing
- Zero-wait imem (ready=1, rsp one cycle after accept) and if_ready=1: one instruction per 3 cycles (FETCH, WAIT, HOLD).
- First request is asserted in the 2nd posedge after rst_n deasserts (IDLE absorbs the reset release).
- Redirect latency: target appears on imem_req_addr the cycle after the pulse, unless a stale response is pending.
- if_* outputs are registered. imem_req_valid and if_valid decode directly from state flops (no input-to-output combinational path).
- rst_n assertion mid-transaction abandons an outstanding fetch. imem is reset on the same rst_n.

## Structure
- Shared package `mips_fetch_pkg`:
  - state enum `fetch_state_t`
  - `RESET_PC_DEFAULT` = 32'h00400020
  - `INSTR_BYTES` = 4
- One sub-module, `fetch_pc_reg`: 32b PC register with async active-low reset to RESET_PC and a load enable. The sequencer computes next-pc and drives it.

## Test plan
- Reset/sequential: release rst_n, imem zero-wait, if_ready=1.
  - First addr is 0x00400020.
  - if_pc sequence 0x00400020, 0x00400024, 0x00400028 at 3-cycle spacing.
  - if_pc_plus4 tracks if_pc+4.
- Backpressure: hold if_ready=0 for 5 cycles in HOLD.
  - if_valid, if_pc and if_instr stay stable.
  - No imem request is issued.
  - Release -> next fetch at if_pc+4.
- Squash: redirect to 0x00400100 while WAIT, response delayed 4 cycles.
  - The late word is never presented.
  - Next request addr is 0x00400100.
  - Only one request is outstanding throughout.
- Redirect in HOLD with if_ready=1 same cycle: held instruction dropped, next fetch addr = redirect_pc.
- Misaligned redirect 0x00400102:
  - misalign_fault=1 and no requests are issued.
  - Aligned redirect 0x00400200 clears the fault and fetches from 0x00400200.
- Wrap, with async reset asserted mid-WAIT:
  - Redirect to 0xFFFFFFFC: fetch there, then next addr 0x00000000.
  - Assert rst_n low mid-WAIT: all outputs return to their reset values immediately.
